// File: rtl/lmi_dcache_tag_nway.sv
// N-way set-associative D-cache tag store: registered lookup, fill, set invalidate, flush walk and victim choice.
// Optional DC_TAG_PARITY_EN adds even parity per entry and a RSP_PERR output.
module lmi_dcache_tag_nway #(
    parameter int WAYS  = 2,
    parameter int WAY_W = 1,
    parameter int IDX_W = 6,
    parameter int TAG_W = 20
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [IDX_W-1:0] REQ_IDX,
    input  logic [TAG_W-1:0] REQ_TAG,
    input  logic             REQ_KSEG1,
    input  logic             REQ_WR_WORD,
    input  logic             REQ_WR_PARTIAL,
    output logic             RSP_VALID,
    output logic             RSP_HIT,
    output logic             RSP_UNCACHED,
    output logic [WAY_W-1:0] RSP_WAY,
    output logic [WAY_W-1:0] RSP_VICTIM,
    output logic             RSP_WR_WORD_HIT,
    output logic             RSP_WR_PARTIAL_HIT,
    input  logic             FILL_VALID,
    input  logic [IDX_W-1:0] FILL_IDX,
    input  logic [WAY_W-1:0] FILL_WAY,
    input  logic [TAG_W-1:0] FILL_TAG,
    input  logic             INV_VALID,
    input  logic [IDX_W-1:0] INV_IDX,
    input  logic             FLUSH_REQ,
`ifdef DC_TAG_PARITY_EN
    output logic             RSP_PERR,
`endif
    output logic             FLUSH_BUSY
);
    localparam int SETS = 1 << IDX_W;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]                    state_q, state_d;
    logic [IDX_W-1:0]              cnt_q, cnt_d;
    logic [SETS-1:0][WAYS-1:0]     valid_q, valid_d;
    logic [TAG_W-1:0]              tag_q [SETS][WAYS];
    logic [TAG_W-1:0]              tag_d [SETS][WAYS];
    logic [WAY_W-1:0]              ptr_q [SETS];
    logic [WAY_W-1:0]              ptr_d [SETS];
`ifdef DC_TAG_PARITY_EN
    logic [SETS-1:0][WAYS-1:0]     par_q, par_d;
    logic                          rsp_perr_q, rsp_perr_d;
`endif

    logic                          rsp_valid_q, rsp_valid_d;
    logic                          rsp_hit_q, rsp_hit_d;
    logic                          rsp_unc_q, rsp_unc_d;
    logic [WAY_W-1:0]              rsp_way_q, rsp_way_d;
    logic [WAY_W-1:0]              rsp_vic_q, rsp_vic_d;
    logic                          rsp_wrw_q, rsp_wrw_d;
    logic                          rsp_wrp_q, rsp_wrp_d;

    logic                          flush_busy, req_fire, cached_hit, perr;
    logic [WAYS-1:0]               way_ok, match;
    logic [WAY_W-1:0]              hit_way, victim;

    assign flush_busy = (state_q == ST_FLUSH);
    assign req_fire   = REQ_VALID & ~flush_busy;

    // Lookup reads the pre-edge array; same-cycle fills/invalidates are not bypassed.
    always_comb begin
        perr    = 1'b0;
        way_ok  = '0;
        match   = '0;
        for (int w = 0; w < WAYS; w++) begin
            way_ok[w] = valid_q[REQ_IDX][w];
`ifdef DC_TAG_PARITY_EN
            if (par_q[REQ_IDX][w] != ^{tag_q[REQ_IDX][w], valid_q[REQ_IDX][w]}) begin
                way_ok[w] = 1'b0;
                perr      = 1'b1;
            end
`endif
            match[w] = way_ok[w] && (tag_q[REQ_IDX][w] == REQ_TAG);
        end
        cached_hit = |match;
        hit_way    = '0;
        victim     = ptr_q[REQ_IDX];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w])   hit_way = WAY_W'(w);
            if (!way_ok[w]) victim  = WAY_W'(w);
        end
        if (WAYS == 1) victim = '0;
    end

    always_comb begin
        rsp_valid_d = req_fire;
        rsp_hit_d   = req_fire & (cached_hit | REQ_KSEG1);
        rsp_unc_d   = req_fire & REQ_KSEG1;
        rsp_way_d   = req_fire ? hit_way : '0;
        rsp_vic_d   = req_fire ? victim : '0;
        rsp_wrw_d   = req_fire & REQ_WR_WORD & cached_hit & ~REQ_KSEG1;
        rsp_wrp_d   = req_fire & REQ_WR_PARTIAL & cached_hit & ~REQ_KSEG1;
`ifdef DC_TAG_PARITY_EN
        rsp_perr_d  = req_fire & perr;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        ptr_d   = ptr_q;
`ifdef DC_TAG_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q == ST_IDLE) begin
            if (FLUSH_REQ) begin
                state_d = ST_FLUSH;
                cnt_d   = '0;
            end
            if (FILL_VALID) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (FILL_WAY == WAY_W'(w)) begin
                        tag_d[FILL_IDX][w]   = FILL_TAG;
                        valid_d[FILL_IDX][w] = 1'b1;
`ifdef DC_TAG_PARITY_EN
                        par_d[FILL_IDX][w]   = ^{FILL_TAG, 1'b1};
`endif
                    end
                end
                ptr_d[FILL_IDX] = (WAYS == 1) ? '0 : FILL_WAY + 1'b1;
            end
            // Applied after the fill so a same-set invalidate wins.
            if (INV_VALID) begin
                valid_d[INV_IDX] = '0;
`ifdef DC_TAG_PARITY_EN
                for (int w = 0; w < WAYS; w++) par_d[INV_IDX][w] = ^{tag_d[INV_IDX][w], 1'b0};
`endif
            end
        end else begin
            valid_d[cnt_q] = '0;
`ifdef DC_TAG_PARITY_EN
            for (int w = 0; w < WAYS; w++) par_d[cnt_q][w] = ^{tag_q[cnt_q][w], 1'b0};
`endif
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(SETS - 1)) state_d = ST_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            valid_q     <= '0;
            ptr_q       <= '{default: '0};
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_unc_q   <= 1'b0;
            rsp_way_q   <= '0;
            rsp_vic_q   <= '0;
            rsp_wrw_q   <= 1'b0;
            rsp_wrp_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_unc_q   <= rsp_unc_d;
            rsp_way_q   <= rsp_way_d;
            rsp_vic_q   <= rsp_vic_d;
            rsp_wrw_q   <= rsp_wrw_d;
            rsp_wrp_q   <= rsp_wrp_d;
        end
    end

`ifdef DC_TAG_PARITY_EN
    // Tags are zeroed on reset so the zero parity bits start out consistent.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tag_q      <= '{default: '0};
            par_q      <= '0;
            rsp_perr_q <= 1'b0;
        end else begin
            tag_q      <= tag_d;
            par_q      <= par_d;
            rsp_perr_q <= rsp_perr_d;
        end
    end
    assign RSP_PERR = rsp_perr_q;
`else
    always_ff @(posedge CLK) tag_q <= tag_d;
`endif

    assign REQ_READY          = ~flush_busy;
    assign FLUSH_BUSY         = flush_busy;
    assign RSP_VALID          = rsp_valid_q;
    assign RSP_HIT            = rsp_hit_q;
    assign RSP_UNCACHED       = rsp_unc_q;
    assign RSP_WAY            = rsp_way_q;
    assign RSP_VICTIM         = rsp_vic_q;
    assign RSP_WR_WORD_HIT    = rsp_wrw_q;
    assign RSP_WR_PARTIAL_HIT = rsp_wrp_q;
endmodule

// File: tb/tb_lmi_dcache_tag_nway.sv
// Directed plus random bench for lmi_dcache_tag_nway against a set/way reference model.
module tb_lmi_dcache_tag_nway;
    localparam int WAYS = 2, WAY_W = 1, IDX_W = 6, TAG_W = 20, SETS = 64;

    logic CLK = 0, RESET = 0;
    logic REQ_VALID = 0, REQ_KSEG1 = 0, REQ_WR_WORD = 0, REQ_WR_PARTIAL = 0;
    logic [IDX_W-1:0] REQ_IDX = '0, FILL_IDX = '0, INV_IDX = '0;
    logic [TAG_W-1:0] REQ_TAG = '0, FILL_TAG = '0;
    logic [WAY_W-1:0] FILL_WAY = '0;
    logic FILL_VALID = 0, INV_VALID = 0, FLUSH_REQ = 0;
    logic REQ_READY, RSP_VALID, RSP_HIT, RSP_UNCACHED, RSP_WR_WORD_HIT, RSP_WR_PARTIAL_HIT, FLUSH_BUSY;
    logic [WAY_W-1:0] RSP_WAY, RSP_VICTIM;

    lmi_dcache_tag_nway #(.WAYS(WAYS), .WAY_W(WAY_W), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
        .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_IDX(REQ_IDX), .REQ_TAG(REQ_TAG), .REQ_KSEG1(REQ_KSEG1),
        .REQ_WR_WORD(REQ_WR_WORD), .REQ_WR_PARTIAL(REQ_WR_PARTIAL),
        .RSP_VALID(RSP_VALID), .RSP_HIT(RSP_HIT), .RSP_UNCACHED(RSP_UNCACHED),
        .RSP_WAY(RSP_WAY), .RSP_VICTIM(RSP_VICTIM), .RSP_WR_WORD_HIT(RSP_WR_WORD_HIT),
        .RSP_WR_PARTIAL_HIT(RSP_WR_PARTIAL_HIT), .FILL_VALID(FILL_VALID), .FILL_IDX(FILL_IDX),
        .FILL_WAY(FILL_WAY), .FILL_TAG(FILL_TAG), .INV_VALID(INV_VALID), .INV_IDX(INV_IDX),
        .FLUSH_REQ(FLUSH_REQ), .FLUSH_BUSY(FLUSH_BUSY));

    always #5 CLK = ~CLK;

    // Reference model: a flush clears everything at once and just blocks for SETS cycles.
    bit          mv [SETS][WAYS];
    int unsigned mt [SETS][WAYS];
    int          mp [SETS];
    int          fl_left = 0;
    int          total = 0, bad = 0;
    logic [8:0]  exp_rsp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        bit hit; int way, vic;
        logic [6:0] r;
        r = '0;
        if (!RESET && REQ_VALID && fl_left == 0) begin
            hit = 0; way = 0; vic = -1;
            for (int w = 0; w < WAYS; w++) begin
                if (!hit && mv[REQ_IDX][w] && mt[REQ_IDX][w] == REQ_TAG) begin hit = 1; way = w; end
                if (vic < 0 && !mv[REQ_IDX][w]) vic = w;
            end
            if (vic < 0) vic = mp[REQ_IDX];
            r = {1'b1, hit | REQ_KSEG1, REQ_KSEG1, way[0], vic[0],
                 REQ_WR_WORD & hit & ~REQ_KSEG1, REQ_WR_PARTIAL & hit & ~REQ_KSEG1};
        end
        @(posedge CLK);
        if (RESET) begin
            for (int s = 0; s < SETS; s++) begin mp[s] = 0; for (int w = 0; w < WAYS; w++) mv[s][w] = 0; end
            fl_left = 0;
        end else if (fl_left > 0) begin
            fl_left--;
        end else begin
            if (FILL_VALID) begin
                mv[FILL_IDX][FILL_WAY] = 1; mt[FILL_IDX][FILL_WAY] = FILL_TAG;
                mp[FILL_IDX] = (FILL_WAY + 1) % WAYS;
            end
            if (INV_VALID) for (int w = 0; w < WAYS; w++) mv[INV_IDX][w] = 0;
            if (FLUSH_REQ) begin
                for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) mv[s][w] = 0;
                fl_left = SETS;
            end
        end
        #1;
        exp_rsp = {r, fl_left > 0, fl_left == 0};
        chk("cycle", {RSP_VALID, RSP_HIT, RSP_UNCACHED, RSP_WAY, RSP_VICTIM, RSP_WR_WORD_HIT,
                      RSP_WR_PARTIAL_HIT, FLUSH_BUSY, REQ_READY}, exp_rsp);
    endtask

    task automatic idle();
        REQ_VALID = 0; REQ_KSEG1 = 0; REQ_WR_WORD = 0; REQ_WR_PARTIAL = 0;
        FILL_VALID = 0; INV_VALID = 0; FLUSH_REQ = 0; RESET = 0;
    endtask

    task automatic lookup(input int idx, input int tag, input bit k1, input bit ww, input bit wp);
        idle(); REQ_VALID = 1; REQ_IDX = IDX_W'(idx); REQ_TAG = TAG_W'(tag);
        REQ_KSEG1 = k1; REQ_WR_WORD = ww; REQ_WR_PARTIAL = wp;
    endtask

    task automatic fill(input int idx, input int way, input int tag);
        FILL_VALID = 1; FILL_IDX = IDX_W'(idx); FILL_WAY = WAY_W'(way); FILL_TAG = TAG_W'(tag);
    endtask

    initial begin
        int n;
        int unsigned pool [4] = '{32'h12345, 32'h0ABCD, 32'hFFFFF, 32'h00001};

        RESET = 1; cyc(); idle(); cyc();
        chk("reset_ready", REQ_READY, 1'b1);
        chk("reset_rsp_valid", RSP_VALID, 1'b0);

        lookup(5, 'h12345, 0, 0, 0); cyc();
        chk("empty_valid", RSP_VALID, 1'b1);
        chk("empty_hit", RSP_HIT, 1'b0);
        chk("empty_victim", RSP_VICTIM, 1'b0);

        idle(); fill(5, 1, 'h12345); cyc();
        lookup(5, 'h12345, 0, 1, 0); cyc();
        chk("fill_hit", RSP_HIT, 1'b1);
        chk("fill_way", RSP_WAY, 1'b1);
        chk("wr_word_hit", RSP_WR_WORD_HIT, 1'b1);

        lookup(9, 0, 1, 0, 1); cyc();
        chk("kseg1_hit", RSP_HIT, 1'b1);
        chk("kseg1_unc", RSP_UNCACHED, 1'b1);
        chk("kseg1_wrp", RSP_WR_PARTIAL_HIT, 1'b0);

        idle(); fill(3, 0, 'h111); cyc();
        idle(); fill(3, 1, 'h222); cyc();
        idle(); fill(3, 0, 'h333); cyc();
        lookup(3, 'h444, 0, 0, 0); cyc();
        chk("rr_victim", RSP_VICTIM, 1'b1);
        idle(); INV_VALID = 1; INV_IDX = 3; cyc();
        lookup(3, 'h222, 0, 0, 0); cyc();
        chk("inv_hit", RSP_HIT, 1'b0);
        chk("inv_victim", RSP_VICTIM, 1'b0);

        lookup(7, 'h777, 0, 0, 0); fill(7, 0, 'h777); cyc();
        chk("no_bypass", RSP_HIT, 1'b0);
        lookup(7, 'h777, 0, 0, 0); fill(7, 1, 'h778); INV_VALID = 1; INV_IDX = 7; cyc();
        chk("pre_inv_hit", RSP_HIT, 1'b1);
        lookup(7, 'h778, 0, 0, 0); cyc();
        chk("inv_wins_a", RSP_HIT, 1'b0);
        lookup(7, 'h777, 0, 0, 0); cyc();
        chk("inv_wins_b", RSP_HIT, 1'b0);

        idle(); fill(10, 0, 'hABC); cyc();
        lookup(10, 'hABC, 0, 0, 0); FLUSH_REQ = 1; cyc();
        chk("flush_req_rsp", RSP_HIT, 1'b1);
        lookup(10, 'hABC, 0, 0, 0); fill(11, 0, 'h1);
        n = 0;
        while (FLUSH_BUSY && n < 200) begin n++; cyc(); end
        chk("flush_cycles", n, SETS);
        lookup(10, 'hABC, 0, 0, 0); cyc();
        chk("post_flush_miss", RSP_HIT, 1'b0);
        lookup(5, 'h12345, 0, 0, 0); cyc();
        chk("post_flush_miss5", RSP_HIT, 1'b0);

        idle(); fill(12, 1, 'h55); cyc();
        idle(); FLUSH_REQ = 1; cyc();
        idle(); for (int i = 0; i < 9; i++) cyc();
        RESET = 1; cyc();
        chk("rst_abort_busy", FLUSH_BUSY, 1'b0);
        idle(); cyc();
        chk("rst_abort_ready", REQ_READY, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            idle();
            REQ_VALID = 1'($urandom % 2); REQ_IDX = IDX_W'($urandom % 4);
            REQ_TAG = TAG_W'(pool[$urandom % 4]); REQ_KSEG1 = ($urandom % 8) == 0;
            REQ_WR_WORD = 1'($urandom % 2); REQ_WR_PARTIAL = 1'($urandom % 2);
            if ($urandom % 3 == 0) fill($urandom % 4, $urandom % 2, pool[$urandom % 4]);
            INV_VALID = ($urandom % 10) == 0; INV_IDX = IDX_W'($urandom % 4);
            FLUSH_REQ = ($urandom % 300) == 0;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
